// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the async-FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_BURST
  } arb_state_e;

  localparam int unsigned STAT_W = 16;

  // Next round-robin index after idx, wrapping at n (n need not be a power of two).
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   idx,
  output logic            found
);

  int unsigned cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (32'(ptr) + k) % NREQ;
      if (!found && req[cand]) begin
        idx   = IW'(cand);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the async FIFO write port (wr_clk domain).
// Define WR_ARB_STATS_EN to add per-requester beat counters and a stall counter.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DSIZE     = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                     wr_clk,
  input  logic                     wr_rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DSIZE-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     wr_full,
  output logic                     wr_inc,
  output logic [DSIZE-1:0]         wr_data,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy
`ifdef WR_ARB_STATS_EN
  ,
  output logic [NREQ*STAT_W-1:0]   stat_beats,
  output logic [STAT_W-1:0]        stat_stall
`endif
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LastBeat = CW'(MAX_BURST - 1);

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

  logic [IW-1:0]   pick_idx;
  logic            pick_found;
  logic            owner_valid;
  logic            xfer;
  logic            burst_done;
  logic [DSIZE-1:0] data_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_data
    assign data_arr[g] = req_data[g*DSIZE +: DSIZE];
  end

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Datapath is purely combinational off the registered owner: zero added latency.
  always_comb begin
    busy        = (state_q == ARB_BURST);
    owner_valid = req_valid[owner_q];
    xfer        = busy & owner_valid & ~wr_full;
    req_ready   = '0;
    if (busy) req_ready[owner_q] = owner_valid & ~wr_full;
    wr_inc      = xfer;
    wr_data     = data_arr[owner_q];
    grant_id    = owner_q;
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    burst_done = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          state_d = ARB_BURST;
        end
      end
      ARB_BURST: begin
        // A stalled but still-valid owner keeps the grant.
        burst_done = (xfer && beat_cnt_q == LastBeat) || !owner_valid;
        if (xfer) beat_cnt_d = beat_cnt_q + 1'b1;
        if (burst_done) begin
          state_d    = ARB_IDLE;
          rr_ptr_d   = IW'(rr_next(32'(owner_q), NREQ));
          beat_cnt_d = '0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state_q    <= ARB_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef WR_ARB_STATS_EN
  logic [STAT_W-1:0] beats_q [NREQ];
  logic [STAT_W-1:0] stall_q;

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      for (int i = 0; i < NREQ; i++) beats_q[i] <= '0;
      stall_q <= '0;
    end else begin
      if (xfer) beats_q[owner_q] <= beats_q[owner_q] + 1'b1;
      if (busy && wr_full && owner_valid) stall_q <= stall_q + 1'b1;
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    assign stat_beats[g*STAT_W +: STAT_W] = beats_q[g];
  end
  assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: grant-level reference model drives expectations.
module tb_fifo_wr_arbiter;

  localparam int unsigned NREQ      = 4;
  localparam int unsigned DSIZE     = 8;
  localparam int unsigned MAX_BURST = 4;
  localparam int unsigned IW        = 2;

  logic                  wr_clk = 1'b0;
  logic                  wr_rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wr_full;
  logic                  wr_inc;
  logic [DSIZE-1:0]      wr_data;
  logic [IW-1:0]         grant_id;
  logic                  busy;
`ifdef WR_ARB_STATS_EN
  logic [NREQ*16-1:0]    stat_beats;
  logic [15:0]           stat_stall;
`endif

  fifo_wr_arbiter #(
    .NREQ      (NREQ),
    .DSIZE     (DSIZE),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .wr_clk    (wr_clk),
    .wr_rst    (wr_rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_full   (wr_full),
    .wr_inc    (wr_inc),
    .wr_data   (wr_data),
    .grant_id  (grant_id),
`ifdef WR_ARB_STATS_EN
    .stat_beats (stat_beats),
    .stat_stall (stat_stall),
`endif
    .busy      (busy)
  );

  always #5 wr_clk = ~wr_clk;

  typedef struct {
    logic [NREQ-1:0] ready;
    logic            inc;
    logic            busy;
    logic [IW-1:0]   gid;
  } cyc_t;

  typedef struct {
    int               id;
    logic [DSIZE-1:0] data;
  } wr_t;

  cyc_t cyc_q[$];
  wr_t  wr_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Producer side: each requester owns a queue of pending beats.
  logic [DSIZE-1:0] src [NREQ][$];
  bit               on [NREQ];
  bit               full_set;
  bit               run;

  // Reference model: a grant is held with a countdown of remaining beats.
  bit               m_granted;
  int               m_owner;
  int               m_start;
  int               m_left;
  logic [15:0]      m_beats [NREQ];
  logic [15:0]      m_stall;
  logic [NREQ-1:0]  cur_v;
  bit               cur_full;
  bit               cur_acc;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_release();
    m_granted = 1'b0;
    m_start   = (m_owner + 1) % NREQ;
  endtask

  task automatic model_edge();
    if (!m_granted) begin
      if (|cur_v) begin
        for (int k = 0; k < NREQ; k++) begin
          if (!m_granted && cur_v[(m_start + k) % NREQ]) begin
            m_owner   = (m_start + k) % NREQ;
            m_granted = 1'b1;
            m_left    = MAX_BURST;
          end
        end
      end
    end else if (cur_acc) begin
      void'(src[m_owner].pop_front());
      m_beats[m_owner] = m_beats[m_owner] + 16'd1;
      m_left--;
      if (m_left == 0) model_release();
    end else begin
      if (cur_full && cur_v[m_owner]) m_stall = m_stall + 16'd1;
      if (!cur_v[m_owner]) model_release();
    end
  endtask

  task automatic drive_and_expect();
    logic [NREQ-1:0] v;
    cyc_t e;
    for (int i = 0; i < NREQ; i++) begin
      v[i] = on[i] && (src[i].size() > 0);
      req_data[i*DSIZE +: DSIZE] = v[i] ? src[i][0] : DSIZE'($urandom);
    end
    req_valid = v;
    wr_full   = full_set;
    cur_v     = v;
    cur_full  = full_set;
    e.ready   = '0;
    e.inc     = 1'b0;
    e.busy    = m_granted;
    e.gid     = IW'(m_owner);
    if (m_granted && v[m_owner] && !full_set) begin
      e.ready[m_owner] = 1'b1;
      e.inc            = 1'b1;
      wr_q.push_back('{m_owner, src[m_owner][0]});
    end
    cur_acc = e.inc;
    cyc_q.push_back(e);
    run = 1'b1;
  endtask

  task automatic step();
    @(posedge wr_clk);
    model_edge();
    #1;
    drive_and_expect();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_on(input logic [NREQ-1:0] mask);
    for (int i = 0; i < NREQ; i++) on[i] = mask[i];
  endtask

  task automatic load(input int id, input int n);
    for (int i = 0; i < n; i++) src[id].push_back(DSIZE'($urandom));
  endtask

`ifdef WR_ARB_STATS_EN
  task automatic chk_stats();
    for (int i = 0; i < NREQ; i++) chk("stat_beats", 64'(stat_beats[i*16 +: 16]), 64'(m_beats[i]));
    chk("stat_stall", 64'(stat_stall), 64'(m_stall));
  endtask
`endif

  // Asserts reset between edges with every requester valid, then checks outputs at once.
  task automatic do_reset();
    @(negedge wr_clk);
    #2;
    run       = 1'b0;
    wr_rst    = 1'b1;
    req_valid = '1;
    wr_full   = 1'b0;
    #1;
    chk("reset_req_ready", 64'(req_ready), 64'(0));
    chk("reset_wr_inc", 64'(wr_inc), 64'(0));
    chk("reset_grant_id", 64'(grant_id), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    m_granted = 1'b0;
    m_owner   = 0;
    m_start   = 0;
    m_left    = 0;
    for (int i = 0; i < NREQ; i++) m_beats[i] = '0;
    m_stall   = '0;
    cur_v     = '0;
    cur_acc   = 1'b0;
    cur_full  = 1'b0;
    cyc_q.delete();
    wr_q.delete();
`ifdef WR_ARB_STATS_EN
    chk_stats();
`endif
    @(posedge wr_clk);
    #1;
    chk("reset_hold_wr_inc", 64'(wr_inc), 64'(0));
    @(negedge wr_clk);
    req_valid = '0;
    wr_rst    = 1'b0;
  endtask

  always @(negedge wr_clk) begin
    if (run) begin
      if (cyc_q.size() == 0) begin
        chk("cycle_queue_underflow", 64'(1), 64'(0));
      end else begin
        cyc_t e;
        e = cyc_q.pop_front();
        chk("req_ready", 64'(req_ready), 64'(e.ready));
        chk("wr_inc", 64'(wr_inc), 64'(e.inc));
        chk("busy", 64'(busy), 64'(e.busy));
        chk("grant_id", 64'(grant_id), 64'(e.gid));
      end
      if (wr_inc) begin
        chk("no_inc_when_full", 64'(wr_full), 64'(0));
        if (wr_q.size() == 0) begin
          chk("unexpected_write", 64'(1), 64'(0));
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("wr_data", 64'(wr_data), 64'(w.data));
          chk("write_owner", 64'(grant_id), 64'(w.id));
        end
      end
    end
  end

  initial begin
    bit drained;
    wr_rst    = 1'b1;
    req_valid = '1;
    req_data  = '0;
    wr_full   = 1'b0;
    run       = 1'b0;
    full_set  = 1'b0;
    set_on('0);
    do_reset();

    // Single requester, burst longer than MAX_BURST.
    load(2, 6);
    set_on(4'b0100);
    steps(12);

    // Everyone continuously valid: strict rotation.
    for (int i = 0; i < NREQ; i++) load(i, 12);
    set_on(4'b1111);
    steps(70);
`ifdef WR_ARB_STATS_EN
    chk_stats();
`endif

    // Back-pressure mid-burst.
    load(0, 8);
    set_on(4'b0001);
    steps(3);
    full_set = 1'b1;
    steps(5);
    full_set = 1'b0;
    steps(20);

    // Owner 1 runs dry after 2 beats while 3 waits.
    load(1, 2);
    load(3, 3);
    set_on(4'b1010);
    steps(12);

    // Randomised traffic and back-pressure.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        on[i] = ($urandom % 4) != 0;
        if (src[i].size() < 4 && ($urandom % 3) == 0) load(i, 1 + int'($urandom % 3));
      end
      full_set = ($urandom % 4) == 0;
      step();
    end
    full_set = 1'b0;
`ifdef WR_ARB_STATS_EN
    chk_stats();
`endif

    // Reset in the middle of a burst, then fresh arbitration from 0.
    load(2, 8);
    set_on(4'b0100);
    steps(3);
    do_reset();
    for (int i = 0; i < NREQ; i++) load(i, 4);
    set_on(4'b1111);
    steps(30);

    // Drain everything that is left, bounded.
    set_on(4'b1111);
    drained = 1'b0;
    for (int n = 0; n < 600 && !drained; n++) begin
      step();
      drained = !m_granted;
      for (int i = 0; i < NREQ; i++) if (src[i].size() != 0) drained = 1'b0;
    end
    chk("drain_complete", 64'(drained), 64'(1));
    steps(2);
    @(negedge wr_clk);
    #1;
    run = 1'b0;
    chk("writes_outstanding", 64'(wr_q.size()), 64'(0));
    chk("cycles_outstanding", 64'(cyc_q.size()), 64'(0));
`ifdef WR_ARB_STATS_EN
    chk_stats();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
